// File: rtl/hit_write_arbiter_pkg.sv
// rtl/hit_write_arbiter_pkg.sv - shared widths, requester count and FSM encodings for the hit write arbiter
package hit_write_arbiter_pkg;

    localparam int NREQ      = 4;
    localparam int SSIDBITS  = 11;
    localparam int NCOLS_HLM = 16;
    localparam int GBITS     = $clog2(NREQ);
    localparam int ENTRYBITS = SSIDBITS + NCOLS_HLM;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOLDOFF    = 2'd1,
        ST_WAIT_READY = 2'd2
    } state_t;

    // Round-robin pointer advance, wrapping modulo NREQ (NREQ need not be a power of two).
    function automatic logic [GBITS-1:0] wrap_inc(input logic [GBITS-1:0] v);
        if (int'(v) == NREQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/hit_write_arbiter_if.sv
// rtl/hit_write_arbiter_if.sv - requester and storage-side signals of the hit write arbiter
interface hit_write_arbiter_if
    import hit_write_arbiter_pkg::*;
();

    logic [NREQ-1:0]           reqValid;
    logic [NREQ-1:0]           reqReady;
    logic [NREQ*SSIDBITS-1:0]  reqSSID;
    logic [NREQ*NCOLS_HLM-1:0] reqHitInfo;
    logic                      storageReady;
    logic [SSIDBITS-1:0]       SSID;
    logic [NCOLS_HLM-1:0]      hitInfo;
    logic                      newAddress;
    logic [GBITS-1:0]          grantID;
    logic                      busy;

    // master is the arbiter itself; slave is the surrounding producers and storage.
    modport master (
        input  reqValid, reqSSID, reqHitInfo, storageReady,
        output reqReady, SSID, hitInfo, newAddress, grantID, busy
    );

    modport slave (
        output reqValid, reqSSID, reqHitInfo, storageReady,
        input  reqReady, SSID, hitInfo, newAddress, grantID, busy
    );

endinterface

// File: rtl/hit_fifo2.sv
// rtl/hit_fifo2.sv - two-entry per-requester hit FIFO with synchronous clear
module hit_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic [1:0]       r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign w_push_ok = i_push && (r_count != 2'd2);
    assign w_pop_ok  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= 2'd0;
            r_mem0  <= '0;
            r_mem1  <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem1 <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                // Only reachable at count 1: the new entry replaces the departing head.
                2'b11: begin
                    r_mem0 <= i_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_mem0;
    assign o_count = r_count;

endmodule

// File: rtl/hit_write_arbiter.sv
// rtl/hit_write_arbiter.sv - round-robin sharing of the storage write port among NREQ hit producers
module hit_write_arbiter
    import hit_write_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                clearMemory,
    hit_write_arbiter_if.master bus
);

    logic [ENTRYBITS-1:0] w_head  [NREQ];
    logic [1:0]           w_count [NREQ];
    logic [NREQ-1:0]      w_nonempty;
    logic [NREQ-1:0]      w_ready;
    logic [NREQ-1:0]      w_push;
    logic [NREQ-1:0]      w_pop;
    logic [GBITS-1:0]     w_sel;
    logic                 w_any;
    logic                 w_issue;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [GBITS-1:0]     r_rr;
    logic [GBITS-1:0]     r_grant;
    logic [SSIDBITS-1:0]  r_ssid;
    logic [NCOLS_HLM-1:0] r_hit;
    logic                 r_new;

    always_comb begin
        w_nonempty = '0;
        w_ready    = '0;
        w_push     = '0;
        w_pop      = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_nonempty[i] = (w_count[i] != 2'd0);
            w_ready[i]    = !clearMemory && (w_count[i] != 2'd2);
            w_push[i]     = bus.reqValid[i] && w_ready[i];
            w_pop[i]      = w_issue && (w_sel == GBITS'(i));
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_fifo
            hit_fifo2 #(
                .WIDTH (ENTRYBITS)
            ) u_fifo (
                .i_clk   (clock),
                .i_clear (clearMemory),
                .i_push  (w_push[g]),
                .i_pop   (w_pop[g]),
                .i_data  ({bus.reqSSID[g*SSIDBITS +: SSIDBITS],
                           bus.reqHitInfo[g*NCOLS_HLM +: NCOLS_HLM]}),
                .o_head  (w_head[g]),
                .o_count (w_count[g])
            );
        end
    endgenerate

    // Scan from the farthest offset down so the nearest non-empty FIFO after r_rr wins.
    always_comb begin : p_rr
        int idx;
        w_sel = '0;
        w_any = 1'b0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr) + k) % NREQ;
            if (w_nonempty[idx]) begin
                w_sel = GBITS'(idx);
                w_any = 1'b1;
            end
        end
    end

    assign w_issue = (r_state == ST_IDLE) && bus.storageReady && w_any && !clearMemory;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_HOLDOFF;
                end
            end
            // storageReady is still stale here; the storage drops it one cycle after the strobe.
            ST_HOLDOFF: begin
                w_state_nxt = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (bus.storageReady) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clearMemory) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_grant <= '0;
            r_ssid  <= '0;
            r_hit   <= '0;
            r_new   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_new   <= w_issue;
            if (w_issue) begin
                r_ssid  <= w_head[w_sel][ENTRYBITS-1 -: SSIDBITS];
                r_hit   <= w_head[w_sel][NCOLS_HLM-1:0];
                r_grant <= w_sel;
                r_rr    <= wrap_inc(w_sel);
            end
        end
    end

    assign bus.reqReady   = w_ready;
    assign bus.SSID       = r_ssid;
    assign bus.hitInfo    = r_hit;
    assign bus.newAddress = r_new;
    assign bus.grantID    = r_grant;
    assign bus.busy       = (|w_nonempty) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_hit_write_arbiter.sv
// tb/tb_hit_write_arbiter.sv - directed self-checking bench for hit_write_arbiter
module tb_hit_write_arbiter;
    import hit_write_arbiter_pkg::*;

    logic clock;
    logic clearMemory;
    int   nvec;
    int   nerr;
    int   npulse;
    logic [31:0] got_ssid  [16];
    logic [31:0] got_grant [16];

    hit_write_arbiter_if bus ();

    hit_write_arbiter dut (
        .clock       (clock),
        .clearMemory (clearMemory),
        .bus         (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input int cycles);
        npulse = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (bus.newAddress === 1'b1) begin
                if (npulse < 16) begin
                    got_ssid[npulse]  = 32'(bus.SSID);
                    got_grant[npulse] = 32'(bus.grantID);
                end
                npulse++;
            end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        npulse = 0;
        for (int i = 0; i < 16; i++) begin
            got_ssid[i]  = '0;
            got_grant[i] = '0;
        end
        clearMemory      = 1'b1;
        bus.reqValid     = 4'hF;
        bus.reqSSID      = '0;
        bus.reqHitInfo   = '0;
        bus.storageReady = 1'b0;

        // Reset held for two edges with all requesters valid
        step();
        step();
        chk("rst_reqReady",   32'(bus.reqReady),   32'h0);
        chk("rst_newAddress", 32'(bus.newAddress), 32'h0);
        chk("rst_SSID",       32'(bus.SSID),       32'h0);
        chk("rst_hitInfo",    32'(bus.hitInfo),    32'h0);
        chk("rst_grantID",    32'(bus.grantID),    32'h0);
        chk("rst_busy",       32'(bus.busy),       32'h0);
        bus.reqValid = 4'h0;
        clearMemory  = 1'b0;
        #1;
        chk("rel_reqReady", 32'(bus.reqReady), 32'hF);
        chk("rel_busy",     32'(bus.busy),     32'h0);

        // Single requester 2
        bus.storageReady = 1'b1;
        bus.reqValid = 4'b0100;
        bus.reqSSID[2*SSIDBITS +: SSIDBITS]      = 11'h005;
        bus.reqHitInfo[2*NCOLS_HLM +: NCOLS_HLM] = 16'h00A1;
        step();
        bus.reqValid = 4'h0;
        chk("single_no_issue_at_push", 32'(bus.newAddress), 32'h0);
        chk("single_busy",             32'(bus.busy),       32'h1);
        step();
        chk("single_newAddress", 32'(bus.newAddress), 32'h1);
        chk("single_SSID",       32'(bus.SSID),       32'h005);
        chk("single_hitInfo",    32'(bus.hitInfo),    32'h00A1);
        chk("single_grantID",    32'(bus.grantID),    32'h2);
        bus.reqValid = 4'b0100;
        bus.reqSSID[2*SSIDBITS +: SSIDBITS]      = 11'h006;
        bus.reqHitInfo[2*NCOLS_HLM +: NCOLS_HLM] = 16'h00A2;
        step();
        bus.reqValid = 4'h0;
        chk("single_gap1", 32'(bus.newAddress), 32'h0);
        step();
        chk("single_gap2", 32'(bus.newAddress), 32'h0);
        step();
        chk("single_second_newAddress", 32'(bus.newAddress), 32'h1);
        chk("single_second_SSID",       32'(bus.SSID),       32'h006);
        chk("single_second_grant",      32'(bus.grantID),    32'h2);
        step();
        chk("single_pulse_width", 32'(bus.newAddress), 32'h0);
        step();
        step();
        chk("single_idle_busy", 32'(bus.busy), 32'h0);

        // Fairness from a fresh round-robin pointer
        clearMemory = 1'b1;
        step();
        clearMemory = 1'b0;
        bus.storageReady = 1'b0;
        bus.reqValid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            bus.reqSSID[i*SSIDBITS +: SSIDBITS]      = 11'(32'h100 + i);
            bus.reqHitInfo[i*NCOLS_HLM +: NCOLS_HLM] = 16'(32'hA100 + i);
        end
        step();
        for (int i = 0; i < NREQ; i++) begin
            bus.reqSSID[i*SSIDBITS +: SSIDBITS]      = 11'(32'h110 + i);
            bus.reqHitInfo[i*NCOLS_HLM +: NCOLS_HLM] = 16'(32'hA110 + i);
        end
        step();
        bus.reqValid = 4'h0;
        chk("fair_full_reqReady", 32'(bus.reqReady),   32'h0);
        chk("fair_no_issue",      32'(bus.newAddress), 32'h0);
        bus.storageReady = 1'b1;
        collect(40);
        chk("fair_pulses", 32'(npulse), 32'd8);
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("fair_grant%0d", p), got_grant[p], 32'(p % 4));
            chk($sformatf("fair_ssid%0d", p),  got_ssid[p],
                (p < 4) ? 32'(32'h100 + p) : 32'(32'h110 + p - 4));
        end
        chk("fair_busy",     32'(bus.busy),     32'h0);
        chk("fair_reqReady", 32'(bus.reqReady), 32'hF);

        // Backpressure on requester 0
        bus.storageReady = 1'b0;
        bus.reqValid = 4'b0001;
        bus.reqSSID[0 +: SSIDBITS] = 11'h0A0;
        step();
        bus.reqSSID[0 +: SSIDBITS] = 11'h0A1;
        step();
        bus.reqSSID[0 +: SSIDBITS] = 11'h0A2;
        chk("bp_reqReady0", 32'(bus.reqReady[0]), 32'h0);
        step();
        bus.reqValid = 4'h0;
        chk("bp_no_issue", 32'(bus.newAddress), 32'h0);
        bus.storageReady = 1'b1;
        collect(12);
        chk("bp_pulses", 32'(npulse),    32'd2);
        chk("bp_ssid0",  got_ssid[0],    32'h0A0);
        chk("bp_ssid1",  got_ssid[1],    32'h0A1);
        chk("bp_grant1", got_grant[1],   32'h0);

        // Push and pop on requester 1 in the same cycle
        bus.storageReady = 1'b0;
        bus.reqValid = 4'b0010;
        bus.reqSSID[1*SSIDBITS +: SSIDBITS] = 11'h051;
        step();
        bus.reqSSID[1*SSIDBITS +: SSIDBITS] = 11'h052;
        bus.storageReady = 1'b1;
        step();
        bus.reqValid = 4'h0;
        chk("pp_newAddress", 32'(bus.newAddress), 32'h1);
        chk("pp_SSID",       32'(bus.SSID),       32'h051);
        chk("pp_grant",      32'(bus.grantID),    32'h1);
        chk("pp_reqReady",   32'(bus.reqReady),   32'hF);
        collect(8);
        chk("pp_pulses", 32'(npulse),  32'd1);
        chk("pp_ssid",   got_ssid[0],  32'h052);
        chk("pp_grant2", got_grant[0], 32'h1);
        chk("pp_busy",   32'(bus.busy), 32'h0);

        // Reset while waiting for storage with three entries queued
        bus.reqValid = 4'b0101;
        bus.reqSSID[0 +: SSIDBITS]          = 11'h0C0;
        bus.reqSSID[2*SSIDBITS +: SSIDBITS] = 11'h0C2;
        step();
        bus.reqSSID[0 +: SSIDBITS]          = 11'h0C1;
        bus.reqSSID[2*SSIDBITS +: SSIDBITS] = 11'h0C3;
        step();
        chk("mr_newAddress", 32'(bus.newAddress), 32'h1);
        chk("mr_SSID",       32'(bus.SSID),       32'h0C2);
        chk("mr_grant",      32'(bus.grantID),    32'h2);
        bus.reqValid = 4'h0;
        bus.storageReady = 1'b0;
        step();
        chk("mr_wait_busy",  32'(bus.busy),       32'h1);
        chk("mr_wait_noiss", 32'(bus.newAddress), 32'h0);
        clearMemory = 1'b1;
        step();
        clearMemory = 1'b0;
        bus.storageReady = 1'b1;
        #1;
        chk("mr_busy",     32'(bus.busy),       32'h0);
        chk("mr_noiss",    32'(bus.newAddress), 32'h0);
        chk("mr_SSID0",    32'(bus.SSID),       32'h0);
        chk("mr_grant0",   32'(bus.grantID),    32'h0);
        chk("mr_reqReady", 32'(bus.reqReady),   32'hF);
        collect(6);
        chk("mr_no_pulses", 32'(npulse), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
